// File: rtl/johnson_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_decoder
//  Description : Converts a stream of N-bit Johnson codes into binary state
//                indices. Flags illegal codes and out-of-order steps, and
//                tracks lock after LOCK_CNT consecutive correct steps.
//                Define JDEC_ERR_COUNT_EN to add the saturating 8-bit
//                err_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module johnson_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [N-1:0]                code_in,
  output logic                        out_valid,
  output logic [$clog2(2*N)-1:0]      idx_out,
  output logic                        illegal,
  output logic                        seq_err,
`ifdef JDEC_ERR_COUNT_EN
  output logic [7:0]                  err_count,
`endif
  output logic                        locked
);

  localparam int              IW       = $clog2(2*N);
  localparam logic [IW-1:0]   LAST_IDX = IW'(2*N - 1);
  localparam logic [7:0]      LOCK_MAX = 8'(LOCK_CNT);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Index implied by the code's popcount; only meaningful if the code is legal.
  function automatic logic [IW-1:0] decode_idx(input logic [N-1:0] code);
    int pop;
    pop = 0;
    for (int i = 0; i < N; i++) pop += int'(code[i]);
    if (code[N-1] || (code == '0)) return IW'(pop);
    else                           return IW'(2*N - pop);
  endfunction

  // Canonical code word for ring position k.
  function automatic logic [N-1:0] code_of(input logic [IW-1:0] k);
    logic [N-1:0] c;
    int           ki;
    ki = int'(k);
    for (int i = 0; i < N; i++) begin
      if (ki <= N) c[i] = (i >= N - ki);
      else         c[i] = (i < 2*N - ki);
    end
    return c;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [IW-1:0]     idx_q,       idx_d;
  logic              illegal_q,   illegal_d;
  logic              seq_err_q,   seq_err_d;
  logic              have_prev_q, have_prev_d;
  logic [IW-1:0]     prev_q,      prev_d;
  logic [7:0]        good_q,      good_d;
  lock_state_t       state_q,     state_d;
  logic [IW-1:0]     dec_idx;
  logic              code_legal;
  logic [IW-1:0]     next_idx;

  // Decode the incoming code and its legality check.
  always_comb begin
    dec_idx    = decode_idx(code_in);
    code_legal = (code_of(dec_idx) == code_in) && (dec_idx <= LAST_IDX);
    next_idx   = (prev_q == LAST_IDX) ? '0 : prev_q + 1'b1;
  end

  // Next-state: step checking, good-step counting and lock transitions.
  always_comb begin
    out_valid_d = in_valid;
    idx_d       = idx_q;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    good_d      = good_q;
    state_d     = state_q;
    if (in_valid) begin
      if (!code_legal) begin
        illegal_d   = 1'b1;
        idx_d       = '0;
        have_prev_d = 1'b0;
        good_d      = '0;
        state_d     = UNLOCKED;
      end else begin
        idx_d  = dec_idx;
        prev_d = dec_idx;
        if (!have_prev_q) begin
          have_prev_d = 1'b1;
          good_d      = '0;
        end else if (dec_idx == next_idx) begin
          good_d = (good_q >= LOCK_MAX) ? LOCK_MAX : good_q + 8'd1;
          if (good_d == LOCK_MAX) state_d = LOCKED;
        end else begin
          // Resynchronise to the new index so one glitch costs one error.
          seq_err_d = 1'b1;
          good_d    = '0;
          state_d   = UNLOCKED;
        end
      end
    end
  end

  // Register all state and outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      have_prev_q <= 1'b0;
      prev_q      <= '0;
      good_q      <= '0;
      state_q     <= UNLOCKED;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      have_prev_q <= have_prev_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      state_q     <= state_d;
    end
  end

`ifdef JDEC_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Count every flagged result, sticking at 255.
  always_comb begin
    err_count_d = err_count_q;
    if ((illegal_d || seq_err_d) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

  assign out_valid = out_valid_q;
  assign idx_out   = idx_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_johnson_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_johnson_decoder
//  Description : Self-checking bench for johnson_decoder (N=4, LOCK_CNT=4).
//                Directed sequences followed by randomized traffic, compared
//                against a behavioural model. Honors JDEC_ERR_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_decoder;

  localparam int N        = 4;
  localparam int LOCK_CNT = 4;
  localparam int IW       = 3;
  localparam int RING     = 2*N;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [N-1:0]  code_in;
  logic          out_valid;
  logic [IW-1:0] idx_out;
  logic          illegal;
  logic          seq_err;
  logic          locked;
`ifdef JDEC_ERR_COUNT_EN
  logic [7:0]    err_count;
`endif

  johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .code_in   (code_in),
    .out_valid (out_valid),
    .idx_out   (idx_out),
    .illegal   (illegal),
    .seq_err   (seq_err),
`ifdef JDEC_ERR_COUNT_EN
    .err_count (err_count),
`endif
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference ring built by clocking a Johnson shift register.
  logic [N-1:0] ring_tbl [RING];

  // Model state and expected outputs after the next rising edge.
  int m_have, m_prev, m_good, m_lock, m_err;
  int e_ov, e_idx, e_ill, e_seq;

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [N-1:0] c);
    for (int k = 0; k < RING; k++) if (ring_tbl[k] == c) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_good = 0; m_lock = 0; m_err = 0;
    e_ov = 0; e_idx = 0; e_ill = 0; e_seq = 0;
  endtask

  task automatic model_step(input bit v, input logic [N-1:0] c);
    int k;
    e_ill = 0; e_seq = 0; e_ov = v;
    if (!v) return;
    k = lookup(c);
    if (k < 0) begin
      e_ill = 1; e_idx = 0; m_have = 0; m_good = 0; m_lock = 0;
    end else begin
      e_idx = k;
      if (!m_have) begin
        m_have = 1; m_good = 0;
      end else if (k == (m_prev + 1) % RING) begin
        if (m_good < LOCK_CNT) m_good++;
        if (m_good == LOCK_CNT) m_lock = 1;
      end else begin
        e_seq = 1; m_good = 0; m_lock = 0;
      end
      m_prev = k;
    end
    if ((e_ill || e_seq) && m_err < 255) m_err++;
  endtask

  task automatic check_outputs();
    chk("out_valid", int'(out_valid), e_ov);
    chk("idx_out",   int'(idx_out),   e_idx);
    chk("illegal",   int'(illegal),   e_ill);
    chk("seq_err",   int'(seq_err),   e_seq);
    chk("locked",    int'(locked),    m_lock);
`ifdef JDEC_ERR_COUNT_EN
    chk("err_count", int'(err_count), m_err);
`endif
  endtask

  // Check the previous cycle's result, then apply a new input.
  task automatic cycle(input bit v, input logic [N-1:0] c);
    @(negedge clk);
    check_outputs();
    in_valid = v;
    code_in  = c;
    model_step(v, c);
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_idx_out",   int'(idx_out),   0);
    chk("rst_illegal",   int'(illegal),   0);
    chk("rst_seq_err",   int'(seq_err),   0);
    chk("rst_locked",    int'(locked),    0);
`ifdef JDEC_ERR_COUNT_EN
    chk("rst_err_count", int'(err_count), 0);
`endif
    in_valid = 1'b0;
    code_in  = '0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] c;
    int           last_k;
    int           r;

    c = '0;
    for (int k = 0; k < RING; k++) begin
      ring_tbl[k] = c;
      c = {~c[0], c[N-1:1]};
    end

    reset = 1'b0; in_valid = 1'b0; code_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Clean ring from 0000 and wrap back to 0000.
    for (int k = 0; k <= RING; k++) cycle(1'b1, ring_tbl[k % RING]);
    // Illegal while locked, then relock.
    cycle(1'b1, 4'b1010);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b1000);
    cycle(1'b1, 4'b1100);
    cycle(1'b1, 4'b1110);
    cycle(1'b1, 4'b1111);
    // Skip and repeat.
    cycle(1'b1, 4'b1000);
    cycle(1'b1, 4'b1110);
    cycle(1'b1, 4'b1110);
    cycle(1'b1, 4'b1111);
    // Gaps between codes.
    cycle(1'b1, 4'b0111);
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b1010);
    cycle(1'b1, 4'b0011);
    cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b0001);
    cycle(1'b0, 4'b0000);
    async_reset_check();

    // Randomized traffic: mostly correct steps with sprinkled faults.
    last_k = 0;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        last_k = (last_k + 1) % RING;
        cycle(1'b1, ring_tbl[last_k]);
      end else if (r < 70) begin
        cycle(1'b0, N'($urandom));
      end else if (r < 78) begin
        cycle(1'b1, ring_tbl[last_k]);
      end else if (r < 86) begin
        last_k = (last_k + 2) % RING;
        cycle(1'b1, ring_tbl[last_k]);
      end else begin
        cycle(1'b1, N'($urandom));
      end
      if (i == 1000) async_reset_check();
    end

    // Long illegal run saturates the error counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, 4'b0101);
    cycle(1'b0, 4'b0000);
`ifdef JDEC_ERR_COUNT_EN
    chk("err_sat", int'(err_count), 255);
`endif
    async_reset_check();
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
